// File: rtl/display_scan_controller.sv
// Four-digit 7-segment scan controller with per-slot blanking guard and frame-aligned double buffering.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN (blank leading zero digits above digit 0).
module display_scan_controller #(
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [15:0] upd_value,
  output logic        upd_ready,
  output logic [1:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_sel_q, digit_sel_d;
  logic [3:0]       nibble_q, nibble_d;
  logic             blank_q, blank_d;
  logic             frame_tick_q, frame_tick_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;

  logic slot_end, boundary, accept, load_pt;

  function automatic logic [3:0] sel_nibble(input logic [15:0] v, input logic [1:0] d);
    case (d)
      2'd0:    return v[3:0];
      2'd1:    return v[7:4];
      2'd2:    return v[11:8];
      default: return v[15:12];
    endcase
  endfunction

  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] d);
    case (d)
      2'd1:    return v[15:4] == 12'h000;
      2'd2:    return v[15:8] == 8'h00;
      2'd3:    return v[15:12] == 4'h0;
      default: return 1'b0;
    endcase
  endfunction

  assign slot_end = (slot_cnt_q == SLOT_LAST);
  assign boundary = (state_q == S_ON) && slot_end && (digit_sel_q == 2'd3);
  assign accept   = upd_valid && !pend_full_q;
  assign load_pt  = boundary || (state_q == S_OFF);

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    digit_sel_d = digit_sel_q;
    if (!enable) begin
      state_d     = S_OFF;
      slot_cnt_d  = '0;
      digit_sel_d = 2'd0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d     = S_GUARD;
          slot_cnt_d  = '0;
          digit_sel_d = 2'd0;
        end
        S_GUARD, S_ON: begin
          if (slot_end) begin
            slot_cnt_d  = '0;
            digit_sel_d = digit_sel_q + 2'd1;
            state_d     = S_GUARD;
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
            if (state_q == S_GUARD && slot_cnt_q == GUARD_LAST) state_d = S_ON;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // Pending only fills away from a load point; at a load point an empty pending is bypassed.
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load_pt) begin
      if (pend_full_q) begin
        disp_d      = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        disp_d = upd_value;
      end
    end else if (accept) begin
      pend_d      = upd_value;
      pend_full_d = 1'b1;
    end

    nibble_d     = sel_nibble(disp_d, digit_sel_d);
    blank_d      = (state_d != S_ON);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (state_d == S_ON && lz_blank(disp_d, digit_sel_d)) blank_d = 1'b1;
`else
    if (state_d == S_ON && digit_sel_d == 2'd3 && 1'b0 && lz_blank(disp_d, digit_sel_d)) blank_d = 1'b1;
`endif
    frame_tick_d = boundary && enable;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      slot_cnt_q   <= '0;
      digit_sel_q  <= 2'd0;
      nibble_q     <= 4'h0;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      digit_sel_q  <= digit_sel_d;
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
    end
  end

  assign upd_ready  = !pend_full_q;
  assign digit_sel  = digit_sel_q;
  assign nibble     = nibble_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scenario bench for display_scan_controller (TICK_DIV=8, GUARD=2) with a digit/nibble scoreboard.
module tb_display_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        upd_valid;
  logic [15:0] upd_value;
  logic        upd_ready;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_tick;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [1:0] d;
    logic [3:0] n;
  } exp_t;

  exp_t sb_q[$];
  logic sb_en      = 1'b0;
  logic prev_blank = 1'b1;

  display_scan_controller #(.TICK_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .upd_valid  (upd_valid),
    .upd_value  (upd_value),
    .upd_ready  (upd_ready),
    .digit_sel  (digit_sel),
    .nibble     (nibble),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each slot's first visible cycle must match the next expected digit/nibble.
  always @(negedge clk) begin
    if (sb_en && prev_blank && !blank) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_underflow: digit_sel=%0d nibble=%h shown with nothing expected", digit_sel, nibble);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({digit_sel, nibble} !== {e.d, e.n})
          $display("FAIL sb_digit: got digit_sel=%0d nibble=%h, expected digit_sel=%0d nibble=%h",
                   digit_sel, nibble, e.d, e.n);
        else passes = passes + 1;
      end
    end
    prev_blank <= blank;
  end

  task automatic push_frame(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = 2'(i);
      e.n = v[4*i +: 4];
      sb_q.push_back(e);
    end
  endtask

  task automatic push_one(input logic [1:0] d, input logic [3:0] n);
    exp_t e;
    e.d = d;
    e.n = n;
    sb_q.push_back(e);
  endtask

  task automatic load_while_off(input logic [15:0] v);
    enable = 1'b0;
    @(negedge clk);
    upd_valid = 1'b1;
    upd_value = v;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!found) $display("FAIL %s: frame_tick not seen within 64 cycles", name);
    else passes = passes + 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; upd_valid = 1'b0; upd_value = 16'h0000;
    repeat (3) @(negedge clk);
    checks = checks + 5;
    if (digit_sel !== 2'd0) $display("FAIL rst_digit_sel: got %0d expected 0", digit_sel); else passes = passes + 1;
    if (nibble !== 4'h0) $display("FAIL rst_nibble: got %h expected 0", nibble); else passes = passes + 1;
    if (blank !== 1'b1) $display("FAIL rst_blank: got %b expected 1", blank); else passes = passes + 1;
    if (upd_ready !== 1'b1) $display("FAIL rst_upd_ready: got %b expected 1", upd_ready); else passes = passes + 1;
    if (frame_tick !== 1'b0) $display("FAIL rst_frame_tick: got %b expected 0", frame_tick); else passes = passes + 1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_scan;
    enable = 1'b0;
    @(negedge clk);
    upd_valid = 1'b1;
    upd_value = 16'h1234;
    @(negedge clk);
    upd_valid = 1'b0;
    checks = checks + 1;
    if (upd_ready !== 1'b1) $display("FAIL bypass_ready: got %b expected 1", upd_ready); else passes = passes + 1;
    sb_q.delete();
    sb_en = 1'b1;
    push_frame(16'h1234);
    push_frame(16'h1234);
    enable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      checks = checks + 3;
      if (blank !== ((k % 8) < 2))
        $display("FAIL scan_blank k=%0d: got %b expected %b", k, blank, ((k % 8) < 2));
      else passes = passes + 1;
      if (digit_sel !== 2'((k / 8) % 4))
        $display("FAIL scan_digit k=%0d: got %0d expected %0d", k, digit_sel, (k / 8) % 4);
      else passes = passes + 1;
      if (frame_tick !== ((k % 32 == 0) && (k != 0)))
        $display("FAIL scan_tick k=%0d: got %b expected %b", k, frame_tick, ((k % 32 == 0) && (k != 0)));
      else passes = passes + 1;
    end
  endtask

  task automatic test_mid_frame_update;
    logic found;
    push_frame(16'h1234);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (digit_sel == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!found) $display("FAIL upd_wait_digit1: digit 1 not reached"); else passes = passes + 1;
    push_frame(16'hABCD);
    upd_valid = 1'b1;
    upd_value = 16'hABCD;
    @(negedge clk);
    upd_valid = 1'b0;
    checks = checks + 1;
    if (upd_ready !== 1'b0) $display("FAIL upd_ready_drop: got %b expected 0", upd_ready); else passes = passes + 1;
  endtask

  task automatic test_back_pressure;
    logic found;
    push_frame(16'h5555);
    upd_valid = 1'b1;
    upd_value = 16'h5555;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
      checks = checks + 1;
      if (upd_ready !== 1'b0) $display("FAIL bp_ready_low: got %b expected 0", upd_ready); else passes = passes + 1;
    end
    checks = checks + 2;
    if (!found) $display("FAIL bp_boundary: frame_tick not seen within 64 cycles"); else passes = passes + 1;
    if (upd_ready !== 1'b1) $display("FAIL bp_ready_after_boundary: got %b expected 1", upd_ready); else passes = passes + 1;
    @(negedge clk);
    upd_valid = 1'b0;
    checks = checks + 1;
    if (upd_ready !== 1'b0) $display("FAIL bp_accept_5555: got ready=%b expected 0", upd_ready); else passes = passes + 1;
    wait_tick("bp_tick_5555_frame");
    wait_tick("bp_tick_after_5555");
  endtask

  task automatic test_enable_drop;
    logic found;
    push_one(2'd0, 4'h5);
    push_one(2'd1, 4'h5);
    push_one(2'd2, 4'h5);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (digit_sel == 2'd2 && !blank) begin
        found = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!found) $display("FAIL drop_wait_digit2: digit 2 ON not reached"); else passes = passes + 1;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks = checks + 3;
      if (blank !== 1'b1) $display("FAIL drop_blank c=%0d: got %b expected 1", i, blank); else passes = passes + 1;
      if (digit_sel !== 2'd0) $display("FAIL drop_digit c=%0d: got %0d expected 0", i, digit_sel); else passes = passes + 1;
      if (frame_tick !== 1'b0) $display("FAIL drop_tick c=%0d: got %b expected 0", i, frame_tick); else passes = passes + 1;
    end
    push_frame(16'h5555);
    enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks = checks + 3;
      if (blank !== ((k % 8) < 2))
        $display("FAIL reen_blank k=%0d: got %b expected %b", k, blank, ((k % 8) < 2));
      else passes = passes + 1;
      if (digit_sel !== 2'(k / 8))
        $display("FAIL reen_digit k=%0d: got %0d expected %0d", k, digit_sel, k / 8);
      else passes = passes + 1;
      if (frame_tick !== 1'b0) $display("FAIL reen_tick k=%0d: got %b expected 0", k, frame_tick); else passes = passes + 1;
    end
    checks = checks + 1;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); else passes = passes + 1;
  endtask

  task automatic test_leading_zero;
    logic exp_b;
    load_while_off(16'h0050);
    push_one(2'd0, 4'h0);
    push_one(2'd1, 4'h5);
`ifndef LEADING_ZERO_SUPPRESS_EN
    push_one(2'd2, 4'h0);
    push_one(2'd3, 4'h0);
`endif
    enable = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      exp_b = ((k % 8) < 2);
`ifdef LEADING_ZERO_SUPPRESS_EN
      if ((k / 8) >= 2) exp_b = 1'b1;
`endif
      checks = checks + 1;
      if (blank !== exp_b) $display("FAIL lzs_blank k=%0d: got %b expected %b", k, blank, exp_b); else passes = passes + 1;
    end
    checks = checks + 1;
    if (sb_q.size() != 0) $display("FAIL lzs_leftover: got %0d entries expected 0", sb_q.size()); else passes = passes + 1;
    sb_en = 1'b0;
  endtask

  task automatic test_async_reset;
    sb_en = 1'b0;
    load_while_off(16'h1234);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    upd_valid = 1'b1;
    upd_value = 16'h9999;
    @(negedge clk);
    upd_valid = 1'b0;
    checks = checks + 3;
    if (upd_ready !== 1'b0) $display("FAIL ar_pending_full: got %b expected 0", upd_ready); else passes = passes + 1;
    if (blank !== 1'b0) $display("FAIL ar_pre_blank: got %b expected 0", blank); else passes = passes + 1;
    if (nibble !== 4'h2) $display("FAIL ar_pre_nibble: got %h expected 2", nibble); else passes = passes + 1;
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 5;
    if (digit_sel !== 2'd0) $display("FAIL ar_digit_sel: got %0d expected 0", digit_sel); else passes = passes + 1;
    if (nibble !== 4'h0) $display("FAIL ar_nibble: got %h expected 0", nibble); else passes = passes + 1;
    if (blank !== 1'b1) $display("FAIL ar_blank: got %b expected 1", blank); else passes = passes + 1;
    if (upd_ready !== 1'b1) $display("FAIL ar_upd_ready: got %b expected 1", upd_ready); else passes = passes + 1;
    if (frame_tick !== 1'b0) $display("FAIL ar_frame_tick: got %b expected 0", frame_tick); else passes = passes + 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks = checks + 3;
    if (blank !== 1'b0) $display("FAIL ar_restart_blank: got %b expected 0", blank); else passes = passes + 1;
    if (digit_sel !== 2'd0) $display("FAIL ar_restart_digit: got %0d expected 0", digit_sel); else passes = passes + 1;
    if (nibble !== 4'h0) $display("FAIL ar_disp_cleared: got %h expected 0", nibble); else passes = passes + 1;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_mid_frame_update();
    test_back_pressure();
    test_enable_drop();
    test_leading_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
